multiport_register_file: RTL and testbench

Parametrised successor to the CPU's single-write, dual-read register file. It adds:
- a configurable number of read ports;
- two write ports with fixed priority;
- optional write-to-read bypass;
- an optional hardwired-zero register;
- a sequential clear engine that zeroes storage after reset or on request.

It sits between decode (read addresses) and writeback (write ports) in the core datapath.

---
 rtl/multiport_register_file.sv | 111 +++++++++++
 tb/tb_multiport_register_file.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/multiport_register_file.sv
// Multi-port register file: NUM_READ combinational read ports, two prioritised write ports,
// optional write-to-read bypass, optional hardwired zero register and a sequential clear
// engine that sweeps storage to zero after reset or on request.
module multiport_register_file #(
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DEPTH      = 32,
   parameter int unsigned ADDR_WIDTH = 5,
   parameter int unsigned NUM_READ   = 2,
   parameter bit          BYPASS     = 1'b1,
   parameter bit          ZERO_REG   = 1'b1
) (
   input  logic                             clk,
   input  logic                             rst_n,
   input  logic [NUM_READ*ADDR_WIDTH-1:0]   rd_addr,
   output logic [NUM_READ*DATA_WIDTH-1:0]   rd_data,
   input  logic                             wr0_en,
   input  logic [ADDR_WIDTH-1:0]            wr0_addr,
   input  logic [DATA_WIDTH-1:0]            wr0_data,
   input  logic                             wr1_en,
   input  logic [ADDR_WIDTH-1:0]            wr1_addr,
   input  logic [DATA_WIDTH-1:0]            wr1_data,
   input  logic                             clear_req,
   output logic                             busy
);

   typedef enum logic [0:0] {StIdle, StClear} state_e;

   localparam logic [ADDR_WIDTH-1:0] LastAddr = ADDR_WIDTH'(DEPTH - 1);

   state_e                  state_q;
   logic [ADDR_WIDTH-1:0]   cnt_q;
   logic                    busy_q;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];
   logic                    wr0_ok;
   logic                    wr1_ok;

   // Address is backed by storage and is not the hardwired zero register.
   function automatic logic addr_legal(input logic [ADDR_WIDTH-1:0] a);
      return (32'(a) < DEPTH) && !(ZERO_REG && (a == '0));
   endfunction

   // Writes only take effect outside the clear sweep and to legal addresses.
   assign wr0_ok = wr0_en && !busy_q && addr_legal(wr0_addr);
   assign wr1_ok = wr1_en && !busy_q && addr_legal(wr1_addr);
   assign busy   = busy_q;

   // Clear engine FSM: reset or clear_req starts a DEPTH-cycle sweep from address 0.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= StClear;
         cnt_q   <= '0;
         busy_q  <= 1'b1;
      end else begin
         unique case (state_q)
            StIdle: begin
               if (clear_req) begin
                  state_q <= StClear;
                  cnt_q   <= '0;
                  busy_q  <= 1'b1;
               end
            end
            StClear: begin
               if (cnt_q == LastAddr) begin
                  state_q <= StIdle;
                  busy_q  <= 1'b0;
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: begin
               state_q <= StIdle;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   // Storage update: sweep zeros while busy, otherwise port 1 lands after port 0 so it wins.
   always_ff @(posedge clk) begin
      if (busy_q) begin
         mem[cnt_q] <= '0;
      end else begin
         if (wr0_ok) mem[wr0_addr] <= wr0_data;
         if (wr1_ok) mem[wr1_addr] <= wr1_data;
      end
   end

   for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
      logic [ADDR_WIDTH-1:0] ra;
      logic [DATA_WIDTH-1:0] lane;

      assign ra = rd_addr[i*ADDR_WIDTH +: ADDR_WIDTH];

      // Read mux: mask, then bypass (port 1 first), then stored value.
      always_comb begin
         lane = '0;
         if (busy_q || !addr_legal(ra)) begin
            lane = '0;
         end else if (BYPASS && wr1_ok && (wr1_addr == ra)) begin
            lane = wr1_data;
         end else if (BYPASS && wr0_ok && (wr0_addr == ra)) begin
            lane = wr0_data;
         end else begin
            lane = mem[ra];
         end
      end

      assign rd_data[i*DATA_WIDTH +: DATA_WIDTH] = lane;
   end

endmodule

// File: tb/tb_multiport_register_file.sv
// Scoreboard bench for multiport_register_file: the driver computes expected outputs from a
// simple array model and queues them; a negedge monitor pops and compares against the DUT.
module tb_multiport_register_file;

   localparam int DW    = 32;
   localparam int DEPTH = 24;
   localparam int AW    = 5;
   localparam int NR    = 3;

   logic             clk;
   logic             rst_n;
   logic [NR*AW-1:0] rd_addr;
   logic [NR*DW-1:0] rd_data;
   logic             wr0_en, wr1_en, clear_req, busy;
   logic [AW-1:0]    wr0_addr, wr1_addr;
   logic [DW-1:0]    wr0_data, wr1_data;

   typedef struct {
      logic             busy;
      logic [NR*DW-1:0] rd;
      int               cyc;
   } exp_t;

   exp_t          exp_q[$];
   logic [DW-1:0] model [DEPTH];
   int            clear_left;
   int            cyc;
   int            n_checks;
   int            n_errors;

   multiport_register_file #(
      .DATA_WIDTH (DW),
      .DEPTH      (DEPTH),
      .ADDR_WIDTH (AW),
      .NUM_READ   (NR),
      .BYPASS     (1'b1),
      .ZERO_REG   (1'b1)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .rd_addr   (rd_addr),
      .rd_data   (rd_data),
      .wr0_en    (wr0_en),
      .wr0_addr  (wr0_addr),
      .wr0_data  (wr0_data),
      .wr1_en    (wr1_en),
      .wr1_addr  (wr1_addr),
      .wr1_data  (wr1_data),
      .clear_req (clear_req),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic bit legal(input logic [AW-1:0] a);
      return (int'(a) < DEPTH) && (a != 0);
   endfunction

   function automatic logic [DW-1:0] expect_read(
      input logic [AW-1:0] a,
      input bit w0e, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
      input bit w1e, input logic [AW-1:0] a1, input logic [DW-1:0] d1);
      if (clear_left > 0 || !legal(a)) return '0;
      if (w1e && a1 == a) return d1;
      if (w0e && a0 == a) return d0;
      return model[a];
   endfunction

   task automatic zero_model();
      for (int i = 0; i < DEPTH; i++) model[i] = '0;
   endtask

   // One clock cycle of stimulus: drive, queue expectation, then advance the model at the edge.
   task automatic step(input bit rst,
                       input bit w0e, input logic [AW-1:0] a0, input logic [DW-1:0] d0,
                       input bit w1e, input logic [AW-1:0] a1, input logic [DW-1:0] d1,
                       input bit clr, input logic [NR*AW-1:0] ra);
      exp_t e;
      rst_n     = rst;
      wr0_en    = w0e;
      wr0_addr  = a0;
      wr0_data  = d0;
      wr1_en    = w1e;
      wr1_addr  = a1;
      wr1_data  = d1;
      clear_req = clr;
      rd_addr   = ra;
      if (!rst) begin
         clear_left = DEPTH;
         zero_model();
      end
      e.busy = (clear_left > 0);
      for (int i = 0; i < NR; i++)
         e.rd[i*DW +: DW] = expect_read(ra[i*AW +: AW], w0e, a0, d0, w1e, a1, d1);
      e.cyc = cyc;
      exp_q.push_back(e);
      @(posedge clk);
      if (rst) begin
         if (clear_left > 0) begin
            clear_left--;
         end else begin
            if (w0e && legal(a0)) model[a0] = d0;
            if (w1e && legal(a1)) model[a1] = d1;
            if (clr) begin
               zero_model();
               clear_left = DEPTH;
            end
         end
      end
      cyc++;
      #1;
   endtask

   function automatic logic [NR*AW-1:0] rand_ra();
      return NR*AW'($urandom);
   endfunction

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, rand_ra());
   endtask

   task automatic read_all();
      for (int a = 0; a < 32; a++)
         step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, {AW'(31 - a), AW'(a), AW'(a)});
   endtask

   // Writes and clear requests issued while busy; all of them must be dropped.
   task automatic busy_noise(input int n);
      for (int i = 0; i < n; i++)
         step(1'b1, 1'b1, AW'($urandom), $urandom, 1'b1, AW'($urandom), $urandom,
              ($urandom_range(0, 3) == 0), rand_ra());
   endtask

   // Monitor: compare every presented cycle against the queued expectation.
   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         exp_t e;
         e = exp_q.pop_front();
         n_checks++;
         if (busy !== e.busy) begin
            n_errors++;
            $display("FAIL busy cycle %0d: got %b expected %b", e.cyc, busy, e.busy);
         end
         for (int i = 0; i < NR; i++) begin
            n_checks++;
            if (rd_data[i*DW +: DW] !== e.rd[i*DW +: DW]) begin
               n_errors++;
               $display("FAIL rd_data%0d cycle %0d addr %0d: got %h expected %h", i, e.cyc,
                        rd_addr[i*AW +: AW], rd_data[i*DW +: DW], e.rd[i*DW +: DW]);
            end
         end
      end
   end

   initial begin
      n_checks   = 0;
      n_errors   = 0;
      cyc        = 0;
      clear_left = DEPTH;
      zero_model();
      rst_n      = 1'b0;
      wr0_en     = 1'b0;
      wr1_en     = 1'b0;
      wr0_addr   = '0;
      wr1_addr   = '0;
      wr0_data   = '0;
      wr1_data   = '0;
      clear_req  = 1'b0;
      rd_addr    = '0;
      @(posedge clk);
      #1;

      // Reset, then the post-reset sweep (busy for exactly DEPTH cycles), then all zeros.
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, rand_ra());
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, rand_ra());
      busy_noise(DEPTH);
      read_all();

      // Basic write with bypass on port 0, then stored value on the next cycle.
      step(1'b1, 1'b1, 5'd5, 32'hDEADBEEF, 1'b0, '0, '0, 1'b0, {5'd5, 5'd4, 5'd5});
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, {5'd0, 5'd5, 5'd5});

      // Same-address collision: port 1 wins both bypass and storage.
      step(1'b1, 1'b1, 5'd7, 32'h11111111, 1'b1, 5'd7, 32'h22222222, 1'b0,
           {5'd7, 5'd7, 5'd5});
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, {5'd5, 5'd7, 5'd7});

      // Zero register and out-of-range writes are dropped and never bypassed.
      step(1'b1, 1'b1, 5'd0, 32'hFFFFFFFF, 1'b1, 5'd30, 32'hFFFFFFFF, 1'b0,
           {5'd24, 5'd30, 5'd0});
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, {5'd23, 5'd30, 5'd0});

      // Fill every register with its index, two per cycle.
      for (int r = 1; r < DEPTH; r += 2)
         step(1'b1, 1'b1, AW'(r), DW'(r), 1'b1, AW'(r + 1), DW'(r + 1), 1'b0, rand_ra());
      read_all();

      // Clear request with a same-cycle write; the sweep overwrites it.
      step(1'b1, 1'b0, '0, '0, 1'b1, 5'd3, 32'hAA, 1'b1, {5'd3, 5'd3, 5'd2});
      busy_noise(DEPTH);
      read_all();

      // Reset ten cycles into a sweep must restart it from the beginning.
      for (int r = 1; r < DEPTH; r++)
         step(1'b1, 1'b1, AW'(r), $urandom, 1'b0, '0, '0, 1'b0, rand_ra());
      step(1'b1, 1'b0, '0, '0, 1'b0, '0, '0, 1'b1, rand_ra());
      busy_noise(10);
      step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0, 1'b0, rand_ra());
      busy_noise(DEPTH);
      read_all();

      // Randomised traffic with collisions, bypass reads, clears and occasional resets.
      for (int n = 0; n < 600; n++) begin
         logic [AW-1:0]    a0, a1;
         logic [NR*AW-1:0] ra;
         a0 = AW'($urandom);
         a1 = ($urandom_range(0, 3) == 0) ? a0 : AW'($urandom);
         ra = rand_ra();
         for (int i = 0; i < NR; i++) begin
            int sel;
            sel = $urandom_range(0, 3);
            if (sel == 0) ra[i*AW +: AW] = a0;
            else if (sel == 1) ra[i*AW +: AW] = a1;
         end
         step(($urandom_range(0, 200) != 0),
              ($urandom_range(0, 1) == 1), a0, $urandom,
              ($urandom_range(0, 1) == 1), a1, $urandom,
              ($urandom_range(0, 60) == 0), ra);
      end
      read_all();

      @(negedge clk);
      #1;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_errors++;
         $display("FAIL scoreboard drain: got %0d pending expected 0", exp_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
